sdram_arb: RTL and testbench

Two-port request arbiter and sequencer in front of the SDRAM controller. Accepts single-word read/write requests from port 0 (micro path) and port 1 (DMA/auxiliary master), grants one at a time, and drives the controller's do_read/do_write request pair with latched address and write data. Returns completion, read data and a timeout error to the granted port. Lets two bus masters share the one SDRAM without either seeing the other's cycles.

---
 rtl/sdram_arb_if.sv | 21 ++
 rtl/sdram_arb.sv | 78 +++++++
 tb/tb_sdram_arb.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_if.sv
// sdram_arb_if: request ports of both masters plus the SDRAM controller handshake.
// slave is the arbiter's view; master is the requesters/controller side.
interface sdram_arb_if;
  logic req0_valid, req1_valid, req0_wr, req1_wr;
  logic [19:0] req0_addx, req1_addx, arb_addx;
  logic [15:0] req0_wdata, req1_wdata, arb_wdata, rdata, sd_rdata;
  logic req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err;
  logic do_read, do_write, sd_done, doing_refresh, busy;
  modport slave (
    input req0_valid, req1_valid, req0_wr, req1_wr, req0_addx, req1_addx,
    input req0_wdata, req1_wdata, sd_done, sd_rdata, doing_refresh,
    output req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err,
    output rdata, do_read, do_write, arb_addx, arb_wdata, busy
  );
  modport master (
    output req0_valid, req1_valid, req0_wr, req1_wr, req0_addx, req1_addx,
    output req0_wdata, req1_wdata, sd_done, sd_rdata, doing_refresh,
    input req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err,
    input rdata, do_read, do_write, arb_addx, arb_wdata, busy
  );
endinterface

// File: rtl/sdram_arb.sv
// sdram_arb: two-port arbiter/sequencer in front of the SDRAM controller.
// Round-robin by default; SDRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module sdram_arb #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic sys_clk,
  input logic sys_rst_l,
  sdram_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);
  state_t state;
  logic [7:0] cnt;
  logic sel, win, grant, fin, tmo, sel_wr;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign sel = !bus.req0_valid;
`else
  logic last;
  assign sel = bus.req0_valid && bus.req1_valid ? !last : bus.req1_valid;
  always_ff @(posedge sys_clk or negedge sys_rst_l)
    if (!sys_rst_l) last <= 1'b1;
    else if (grant) last <= sel;
`endif
  assign grant = state == IDLE && !bus.doing_refresh && (bus.req0_valid || bus.req1_valid);
  assign sel_wr = sel ? bus.req1_wr : bus.req0_wr;
  assign fin = bus.sd_done || cnt == TMO;
  // a late sd_done in the timeout cycle still counts as a good completion
  assign tmo = cnt == TMO && !bus.sd_done;
  assign bus.busy = state != IDLE;
  always_ff @(posedge sys_clk or negedge sys_rst_l)
    if (!sys_rst_l) begin
      state <= IDLE;
      cnt <= '0;
      win <= 1'b0;
      bus.req0_ack <= 1'b0;
      bus.req1_ack <= 1'b0;
      bus.req0_done <= 1'b0;
      bus.req1_done <= 1'b0;
      bus.req0_err <= 1'b0;
      bus.req1_err <= 1'b0;
      bus.do_read <= 1'b0;
      bus.do_write <= 1'b0;
      bus.arb_addx <= '0;
      bus.arb_wdata <= '0;
      bus.rdata <= '0;
    end else begin
      bus.req0_ack <= 1'b0;
      bus.req1_ack <= 1'b0;
      bus.req0_done <= 1'b0;
      bus.req1_done <= 1'b0;
      bus.req0_err <= 1'b0;
      bus.req1_err <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          state <= BUSY;
          win <= sel;
          cnt <= '0;
          bus.req0_ack <= !sel;
          bus.req1_ack <= sel;
          bus.arb_addx <= sel ? bus.req1_addx : bus.req0_addx;
          bus.arb_wdata <= sel ? bus.req1_wdata : bus.req0_wdata;
          bus.do_write <= sel_wr;
          bus.do_read <= !sel_wr;
        end
        BUSY: if (fin) begin
          state <= DONE;
          bus.do_read <= 1'b0;
          bus.do_write <= 1'b0;
          bus.req0_done <= !win;
          bus.req1_done <= win;
          bus.req0_err <= tmo && !win;
          bus.req1_err <= tmo && win;
          if (bus.sd_done && bus.do_read) bus.rdata <= bus.sd_rdata;
        end else cnt <= cnt + {7'd0, ~&cnt};
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: vector table, hand sequences and a randomized run of sdram_arb
// against a timestamp-based transaction model, with TIMEOUT_CYC = 4.
module tb_sdram_arb;
  localparam int T = 4;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  typedef struct {
    bit v0, v1, wr;
    logic [19:0] a0, a1;
    logic [15:0] d0, d1, srd;
    int lat;
    bit ep, eerr;
    logic [15:0] erd;
    int edox;
  } vec_t;
  logic sys_clk = 1'b0;
  logic sys_rst_l = 1'b1;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[7];
  sdram_arb_if b();
  sdram_arb #(.TIMEOUT_CYC(T)) dut (.sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .bus(b));
  always #5 sys_clk = ~sys_clk;

  function automatic void check(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endfunction

  task automatic clear_inputs();
    b.req0_valid = 0; b.req1_valid = 0; b.req0_wr = 0; b.req1_wr = 0;
    b.req0_addx = 0; b.req1_addx = 0; b.req0_wdata = 0; b.req1_wdata = 0;
    b.sd_done = 0; b.sd_rdata = 0; b.doing_refresh = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge sys_clk) sys_rst_l = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk) sys_rst_l = 1'b1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int n, j, dox;
    @(negedge sys_clk);
    b.req0_valid = v.v0; b.req1_valid = v.v1; b.req0_wr = v.wr; b.req1_wr = v.wr;
    b.req0_addx = v.a0; b.req1_addx = v.a1; b.req0_wdata = v.d0; b.req1_wdata = v.d1;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!(b.req0_ack || b.req1_ack) && n < 16);
    b.req0_valid = 0; b.req1_valid = 0;
    check($sformatf("v%0d_ack", i), 64'({b.req0_ack, b.req1_ack, n}), 64'({!v.ep, v.ep, 32'd1}));
    check($sformatf("v%0d_bus", i), 64'({b.do_read, b.do_write, b.arb_addx, b.arb_wdata}),
          64'({!v.wr, v.wr, v.ep ? v.a1 : v.a0, v.ep ? v.d1 : v.d0}));
    dox = 0; j = 0;
    while (!(b.req0_done || b.req1_done) && j < 16) begin
      dox += int'(b.do_read || b.do_write);
      b.sd_done = j == v.lat;
      b.sd_rdata = b.sd_done ? v.srd : 16'($urandom);
      @(negedge sys_clk); j++;
    end
    b.sd_done = 0;
    check($sformatf("v%0d_done", i), 64'({b.req0_done, b.req1_done, b.req0_err, b.req1_err, b.rdata}),
          64'({!v.ep, v.ep, v.eerr && !v.ep, v.eerr && v.ep, v.erd}));
    check($sformatf("v%0d_dox", i), 64'(dox), 64'(v.edox));
  endtask

  task automatic rand_run(input int cycles);
    int g = -100, fin = -100, lat = 0, w = 0;
    bit gwr = 0, gerr = 0, last = 1;
    bit v[2], wr[2];
    logic [19:0] ad[2], gaddx = 0, eaddx = 0;
    logic [15:0] wd[2], gwd = 0, ewd = 0, erd = 0, cap = 0;
    logic [60:0] exp_o, act_o;
    for (int p = 0; p < 2; p++) begin v[p] = 0; wr[p] = 0; ad[p] = 0; wd[p] = 0; end
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      if (k == g) begin eaddx = gaddx; ewd = gwd; end
      if (k == fin && !gerr && !gwr) erd = cap;
      exp_o = {k == g && w == 0, k == g && w == 1, k == fin && w == 0, k == fin && w == 1,
               k == fin && gerr && w == 0, k == fin && gerr && w == 1,
               k >= g && k < fin && !gwr, k >= g && k < fin && gwr, k >= g && k <= fin,
               eaddx, ewd, erd};
      act_o = {b.req0_ack, b.req1_ack, b.req0_done, b.req1_done, b.req0_err, b.req1_err,
               b.do_read, b.do_write, b.busy, b.arb_addx, b.arb_wdata, b.rdata};
      check($sformatf("rand_c%0d", k), 64'(act_o), 64'(exp_o));
      for (int p = 0; p < 2; p++)
        if (v[p] && k == g && w == p) v[p] = 0;
        else if (v[p] && $urandom_range(15) == 0) v[p] = 0;
        else if (!v[p] && $urandom_range(2) == 0) begin
          v[p] = 1; wr[p] = 1'($urandom); ad[p] = 20'($urandom); wd[p] = 16'($urandom);
        end
      b.req0_valid = v[0]; b.req0_wr = wr[0]; b.req0_addx = ad[0]; b.req0_wdata = wd[0];
      b.req1_valid = v[1]; b.req1_wr = wr[1]; b.req1_addx = ad[1]; b.req1_wdata = wd[1];
      b.doing_refresh = $urandom_range(5) == 0;
      b.sd_rdata = 16'($urandom);
      b.sd_done = (k >= g && k < fin) ? k == g + lat : $urandom_range(3) == 0;
      if (k == g + lat) cap = b.sd_rdata;
      // access plan: done follows sd_done by one cycle, or aborts T+1 cycles after grant
      if (k > fin && !b.doing_refresh && (v[0] || v[1])) begin
        w = (v[0] && v[1]) ? (FP ? 0 : int'(!last)) : int'(v[1]);
        last = w == 1;
        g = k + 1;
        lat = $urandom_range(T + 2, 0);
        gerr = lat > T;
        fin = g + (gerr ? T : lat) + 1;
        gwr = wr[w]; gaddx = ad[w]; gwd = wd[w];
      end
    end
    clear_inputs();
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 0, 0, 20'h81234, 20'h0, 16'h0, 16'h0, 16'hBEEF, 4, 0, 0, 16'hBEEF, 5};
    tbl[1] = '{0, 1, 1, 20'h0, 20'h000FF, 16'h0, 16'h1234, 16'h9999, 0, 1, 0, 16'hBEEF, 1};
    tbl[2] = '{1, 1, 0, 20'h11111, 20'h22222, 16'h0, 16'h0, 16'h0A0A, 2, 0, 0, 16'h0A0A, 3};
    tbl[3] = '{1, 1, 0, 20'h30003, 20'h40004, 16'h0, 16'h0, 16'h5555, 1, !FP, 0, 16'h5555, 2};
    tbl[4] = '{1, 0, 0, 20'h50005, 20'h0, 16'h0, 16'h0, 16'hDEAD, 7, 0, 1, 16'h5555, 5};
    tbl[5] = '{0, 1, 0, 20'h0, 20'h60006, 16'h0, 16'h0, 16'hC3C3, 3, 1, 0, 16'hC3C3, 4};
    tbl[6] = '{1, 1, 1, 20'h70007, 20'h80008, 16'h1111, 16'h2222, 16'h0, 5, 0, 1, 16'hC3C3, 5};
    do_reset();
    check("reset_state", 64'({b.req0_ack, b.req1_ack, b.req0_done, b.req1_done, b.req0_err, b.req1_err,
          b.do_read, b.do_write, b.busy, b.arb_addx, b.arb_wdata, b.rdata}), 64'(0));
    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);
    // both masters hold writes continuously
    do_reset();
    @(negedge sys_clk);
    b.req0_valid = 1; b.req1_valid = 1; b.req0_wr = 1; b.req1_wr = 1;
    b.req0_addx = 20'h0AAAA; b.req1_addx = 20'h15555; b.req0_wdata = 16'h1111; b.req1_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      bit ep;
      ep = !FP && i % 2 == 1;
      n = 0;
      do begin @(negedge sys_clk); n++; end while (!(b.req0_ack || b.req1_ack) && n < 16);
      check($sformatf("rr%0d_ack", i), 64'({b.req0_ack, b.req1_ack, n}), 64'({!ep, ep, i == 0 ? 32'd1 : 32'd2}));
      check($sformatf("rr%0d_wdata", i), 64'({b.do_write, b.arb_wdata}), 64'({1'b1, ep ? 16'h2222 : 16'h1111}));
      b.sd_done = 1;
      @(negedge sys_clk) b.sd_done = 0;
      check($sformatf("rr%0d_done", i), 64'({b.req0_done, b.req1_done, b.req0_err, b.req1_err}), 64'({!ep, ep, 2'b00}));
    end
    clear_inputs();
    // refresh holds off a pending request
    @(negedge sys_clk);
    b.doing_refresh = 1; b.req1_valid = 1; b.req1_addx = 20'h40001;
    n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge sys_clk); n += int'(b.req1_ack); end
    check("refresh_hold", 64'(n), 64'(0));
    b.doing_refresh = 0;
    @(negedge sys_clk);
    check("refresh_ack", 64'({b.req0_ack, b.req1_ack, b.do_read, b.arb_addx}), 64'({2'b01, 1'b1, 20'h40001}));
    b.req1_valid = 0; b.sd_done = 1; b.sd_rdata = 16'h7777;
    @(negedge sys_clk) b.sd_done = 0;
    check("refresh_done", 64'({b.req1_done, b.req1_err, b.rdata}), 64'({2'b10, 16'h7777}));
    // reset in the middle of a write
    @(negedge sys_clk);
    b.req0_valid = 1; b.req0_wr = 1; b.req0_addx = 20'h05A5A; b.req0_wdata = 16'hABCD;
    @(negedge sys_clk);
    check("rst_pre", 64'({b.req0_ack, b.do_write, b.busy}), 64'(3'b111));
    b.req0_valid = 0; b.req1_valid = 1; b.req1_wr = 0; b.req1_addx = 20'h10002;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_l = 0;
    #1;
    check("rst_async", 64'({b.do_read, b.do_write, b.busy, b.req0_ack, b.req1_ack, b.req0_done, b.req1_done,
          b.arb_addx, b.arb_wdata}), 64'(0));
    @(negedge sys_clk) sys_rst_l = 1;
    @(negedge sys_clk);
    check("rst_regrant", 64'({b.req0_ack, b.req1_ack, b.do_read, b.do_write, b.arb_addx}),
          64'({4'b0110, 20'h10002}));
    b.req1_valid = 0; b.sd_done = 1; b.sd_rdata = 16'h3C3C;
    @(negedge sys_clk) b.sd_done = 0;
    check("rst_done", 64'({b.req0_done, b.req1_done, b.req1_err, b.rdata}), 64'({3'b010, 16'h3C3C}));
    do_reset();
    rand_run(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
